edge_generator: RTL
===================

Name: edge_generator

Overview:
- Inverse of the EdgeDetector block: converts single-cycle event strobes into edges on a level signal.
- Each accepted event produces one transition in toggle mode, or one high pulse in rise-only mode.
- Every transition holds for a minimum number of cycles, so a downstream EdgeDetector or a slow/synchronised receiver sees every edge.
- Events arriving during a hold are queued in a saturating pending counter.

Parameters:
- p_RISE_ONLY, 0, 0: each event toggles o_signal. 1: each event emits a high pulse (rise, then fall).
- p_HOLD, 2, minimum cycles o_signal stays stable after any transition; legal range >= 1.
- p_PEND_WIDTH, 4, width of the pending-event counter; maximum pending is 2^p_PEND_WIDTH-1.
- p_IDLE_LEVEL, 0, o_signal level after reset.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_event  input  1  event strobe, sampled every rising edge; each high cycle is one event.
- i_clear  input  1  synchronous flush of pending count and overflow flag.
- o_signal  output  1  generated level signal, registered.
- o_busy  output  1  high while a hold or pulse phase is in progress, registered.
- o_pending  output  p_PEND_WIDTH  number of queued events, registered.
- o_overflow  output  1  sticky flag: an event was dropped because the counter was full.

Behaviour:
- Reset (async assert, sync release): o_signal=p_IDLE_LEVEL, state IDLE, hold counter 0, o_pending=0, o_overflow=0, o_busy=0.
- Request: a transition is requested when i_event=1 or o_pending>0.
- Toggle mode states: IDLE, HOLD.
  - In IDLE with a request at edge k: o_signal inverts at edge k (visible cycle k+1), and the block enters HOLD for p_HOLD cycles.
  - Next transition is possible at edge k+p_HOLD at the earliest.
  - Latency from event to edge is 1 cycle when IDLE with o_pending=0.
- Rise-only mode states: IDLE, HIGH, LOW.
  - A request in IDLE sets o_signal=~p_IDLE_LEVEL and the block enters HIGH for p_HOLD cycles.
  - o_signal then returns to p_IDLE_LEVEL and the block enters LOW for p_HOLD cycles.
  - Next rise is possible at edge k+2*p_HOLD at the earliest.
- End of HOLD/LOW:
  - With a request: the next transition is taken in the same edge, with no idle cycle.
  - With no request: return to IDLE.
- Consumption order: a pending event is consumed before the current-cycle event.
  - Transition taken with i_event=1 and o_pending>0: o_pending unchanged (one consumed, one added).
  - Transition taken with i_event=1 and o_pending=0: event consumed directly.
  - No transition taken and i_event=1: o_pending+1.
- Saturation: i_event=1 that would increment o_pending at max is dropped, and o_overflow<=1. The counter never wraps.
- i_clear (priority over i_event in the same cycle):
  - o_pending<=0, o_overflow<=0, and any same-cycle i_event is discarded.
  - An in-progress HOLD/HIGH/LOW phase completes normally; in rise-only mode a started pulse always falls.
- o_busy=1 in HOLD/HIGH/LOW, 0 in IDLE.
- Reset asserted mid-phase: all state returns to reset values immediately, with no completion of the pulse.
- Width: the hold counter is sized for p_HOLD.

Test Plan:
- Toggle mode, p_HOLD=2, p_IDLE_LEVEL=0:
  - Stimulus: single i_event.
  - Response: o_signal 0->1 one cycle later; o_busy high 2 cycles then 0; o_pending stays 0.
- Toggle mode, p_HOLD=2:
  - Stimulus: i_event high for 5 consecutive cycles.
  - Response: transitions at edges 0,2,4,6,8; o_pending peaks at 2 and ends at 0; final o_signal=1; no overflow.
- Toggle mode, p_HOLD=8, p_PEND_WIDTH=2:
  - Stimulus: 6 back-to-back events.
  - Response: 1 immediate toggle; o_pending saturates at 3; o_overflow=1 from the 5th event; exactly 4 transitions total, each 8 cycles apart.
- Rise-only mode, p_HOLD=3:
  - Stimulus: 2 back-to-back events.
  - Response: high 3 cycles, low 3 cycles, high 3 cycles, then low and IDLE; total 12 cycles busy.
- i_clear and reset:
  - Stimulus: i_clear with o_pending=3 and o_overflow=1.
  - Response: both 0 next cycle; the current phase still completes.
  - Stimulus: i_rst_n low mid-HIGH.
  - Response: o_signal=p_IDLE_LEVEL immediately.
- Loopback:
  - Setup: o_signal feeds EdgeDetector in both-edge mode.
  - Stimulus: 10 events spaced randomly, 1–5 cycles apart, with p_HOLD=2.
  - Response: exactly 10 detector pulses; o_overflow=0.

Source files
------------

// File: rtl/edge_generator.sv
// -----------------------------------------------------------------------------
// edge_generator
//
// Converts single-cycle event strobes into edges on a level signal. This is the
// inverse of an edge detector. Every transition is held stable for at least
// p_HOLD cycles, so a downstream detector or a slow receiver sees every edge.
// Events that arrive during a hold are queued in a saturating pending counter.
//
// Modes:
//   p_RISE_ONLY = 0 : each event toggles o_signal            (IDLE, HOLD)
//   p_RISE_ONLY = 1 : each event emits one high pulse         (IDLE, HIGH, LOW)
//
// Ports:
//   i_clk       clock, all logic on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_event     event strobe; every high cycle is one event
//   i_clear     synchronous flush of pending count and overflow flag
//   o_signal    generated level signal (registered)
//   o_busy      high while a hold / pulse phase is in progress (registered)
//   o_pending   number of queued events (registered)
//   o_overflow  sticky: an event was dropped because the queue was full
// -----------------------------------------------------------------------------
module edge_generator #(
  parameter int unsigned p_RISE_ONLY  = 32'd0,
  parameter int unsigned p_HOLD       = 32'd2,
  parameter int unsigned p_PEND_WIDTH = 32'd4,
  parameter logic        p_IDLE_LEVEL = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_event,
  input  logic                    i_clear,
  output logic                    o_signal,
  output logic                    o_busy,
  output logic [p_PEND_WIDTH-1:0] o_pending,
  output logic                    o_overflow
);

  // The hold counter counts down from p_HOLD-1 to 0, so it only needs to
  // represent p_HOLD-1.
  localparam int unsigned LP_CNT_W = (p_HOLD > 32'd1) ? $clog2(p_HOLD) : 32'd1;

  typedef logic [LP_CNT_W-1:0]     cnt_t;
  typedef logic [p_PEND_WIDTH-1:0] pend_t;

  localparam cnt_t  LP_CNT_RELOAD = cnt_t'(p_HOLD - 32'd1);
  localparam cnt_t  LP_CNT_ZERO   = cnt_t'(32'd0);
  localparam cnt_t  LP_CNT_ONE    = cnt_t'(32'd1);
  localparam pend_t LP_PEND_ZERO  = pend_t'(32'd0);
  localparam pend_t LP_PEND_ONE   = pend_t'(32'd1);
  localparam pend_t LP_PEND_MAX   = {p_PEND_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  state_t state_r, state_s;
  cnt_t   cnt_r,   cnt_s;
  logic   signal_r, signal_s;
  logic   busy_r,   busy_s;
  pend_t  pend_r,   pend_s;
  logic   ovf_r,    ovf_s;

  logic   req_s;
  logic   take_s;
  logic   hold_done_s;

  // State, counter and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= LP_CNT_ZERO;
      signal_r <= p_IDLE_LEVEL;
      busy_r   <= 1'b0;
      pend_r   <= LP_PEND_ZERO;
      ovf_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      signal_r <= signal_s;
      busy_r   <= busy_s;
      pend_r   <= pend_s;
      ovf_r    <= ovf_s;
    end
  end

  // Next-state, transition and pending-queue logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    signal_s    = signal_r;
    pend_s      = pend_r;
    ovf_s       = ovf_r;
    take_s      = 1'b0;
    hold_done_s = (cnt_r == LP_CNT_ZERO);
    // A clear flushes the queue and discards the same-cycle event, so neither
    // may start a new transition in that cycle.
    req_s       = !i_clear && (i_event || (pend_r != LP_PEND_ZERO));

    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          take_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HOLD, ST_LOW: begin
        if (hold_done_s) begin
          if (req_s) begin
            // Back-to-back transition with no idle cycle in between.
            take_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_r - LP_CNT_ONE;
        end
      end
      ST_HIGH: begin
        // A started pulse always falls, regardless of clear or new events.
        if (hold_done_s) begin
          signal_s = p_IDLE_LEVEL;
          state_s  = ST_LOW;
          cnt_s    = LP_CNT_RELOAD;
        end else begin
          cnt_s = cnt_r - LP_CNT_ONE;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        signal_s = p_IDLE_LEVEL;
        cnt_s    = LP_CNT_ZERO;
      end
    endcase

    if (take_s) begin
      cnt_s = LP_CNT_RELOAD;
      if (p_RISE_ONLY != 32'd0) begin
        signal_s = ~p_IDLE_LEVEL;
        state_s  = ST_HIGH;
      end else begin
        signal_s = ~signal_r;
        state_s  = ST_HOLD;
      end
    end else begin
      cnt_s = cnt_s;
    end

    // Pending events are consumed before the current-cycle event: with both
    // present the count is unchanged (one out, one in).
    if (i_clear) begin
      pend_s = LP_PEND_ZERO;
      ovf_s  = 1'b0;
    end else if (take_s) begin
      if ((pend_r != LP_PEND_ZERO) && !i_event) begin
        pend_s = pend_r - LP_PEND_ONE;
      end else begin
        pend_s = pend_r;
      end
    end else if (i_event) begin
      if (pend_r == LP_PEND_MAX) begin
        ovf_s = 1'b1;
      end else begin
        pend_s = pend_r + LP_PEND_ONE;
      end
    end else begin
      pend_s = pend_r;
    end

    busy_s = (state_s != ST_IDLE);
  end

  assign o_signal   = signal_r;
  assign o_busy     = busy_r;
  assign o_pending  = pend_r;
  assign o_overflow = ovf_r;

endmodule
